// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer:
// branch type codes, entry layout and direction-counter helpers.
package btb_pkg;

    localparam logic [2:0] TYPE_FORMAL = 3'd0;
    localparam logic [2:0] TYPE_BRANCH = 3'd1;
    localparam logic [2:0] TYPE_JUMP   = 3'd2;
    localparam logic [2:0] TYPE_CALL   = 3'd3;
    localparam logic [2:0] TYPE_RET    = 3'd4;

    localparam int FETCH_BYTES = 32;

    // Widest-configuration view of one entry; the arrays store only the bits each build needs.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [2:0]  btype;
        logic [31:0] target;
        logic [3:0]  cnt;
    } btbEntry_t;

    // Weakly taken is MSB set with the rest clear; weakly not-taken is one below it.
    function automatic logic [3:0] cntInit(input logic taken, input int w);
        logic [3:0] msb;
        msb = 4'd1 << (w - 1);
        return taken ? msb : (msb - 4'd1);
    endfunction

    function automatic logic [3:0] cntSat(input logic [3:0] c, input logic up, input int w);
        logic [3:0] cmax;
        cmax = 4'((5'd1 << w) - 5'd1);
        if (up)
            return (c == cmax) ? c : (c + 4'd1);
        return (c == 4'd0) ? c : (c - 4'd1);
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Replacement choice for one set: lowest invalid way, else the round-robin way.
module btb_victim_sel
    import btb_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  validVec,
    input  logic [WAY_W-1:0] rrPtr,
    output logic [WAY_W-1:0] victim,
    output logic [WAY_W-1:0] nextPtr
);

    always_comb begin
        victim  = rrPtr;
        nextPtr = (WAYS == 1) ? '0 : rrPtr + 1'b1;
        // Descending scan so the lowest invalid way is the one left standing.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validVec[w]) begin
                victim  = WAY_W'(w);
                nextPtr = rrPtr;
            end
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: registered one-cycle lookup of the next fetch PC and
// branch type, with an update/allocate path using round-robin replacement.
module btb_assoc
    import btb_pkg::*;
#(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 256,
    parameter  int CNT_W = 2,
    parameter  int OFF_W = 5,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 32 - OFF_W - IDX_W,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             InstPcAble,
    input  logic [31:0]      InstPc,
    input  logic             UpAble,
    input  logic [31:0]      UpPc,
    input  logic [2:0]       UpType,
    input  logic [31:0]      UpTaget,
    input  logic             UpTaken,
    input  logic             FlushAble,
    output logic             InstNextAble,
    output logic [31:0]      InstNextPc,
    output logic [2:0]       InstNextType,
    output logic             InstNextHit,
    output logic [WAY_W-1:0] InstNextWay
);

    logic [WAYS-1:0]  validQ [SETS];
    logic [WAY_W-1:0] rrQ    [SETS];
    logic [TAG_W-1:0] tagMem [SETS][WAYS];
    logic [2:0]       typeMem[SETS][WAYS];
    logic [31:0]      tgtMem [SETS][WAYS];
    logic [CNT_W-1:0] cntMem [SETS][WAYS];

    logic [IDX_W-1:0] lkIdx;
    logic [TAG_W-1:0] lkTag;
    logic             lkHit;
    logic [WAY_W-1:0] lkWay;
    logic [2:0]       lkType;
    logic [31:0]      lkFall, lkNext;

    assign lkIdx  = InstPc[OFF_W+IDX_W-1:OFF_W];
    assign lkTag  = InstPc[31:OFF_W+IDX_W];
    assign lkFall = {InstPc[31:OFF_W], {OFF_W{1'b0}}} + 32'(FETCH_BYTES);

    always_comb begin
        lkHit  = 1'b0;
        lkWay  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (validQ[lkIdx][w] && tagMem[lkIdx][w] == lkTag) begin
                lkHit = 1'b1;
                lkWay = WAY_W'(w);
            end
        end
        lkType = TYPE_FORMAL;
        lkNext = lkFall;
        if (lkHit) begin
            lkType = typeMem[lkIdx][lkWay];
            lkNext = (lkType == TYPE_BRANCH && !cntMem[lkIdx][lkWay][CNT_W-1]) ?
                     lkFall : tgtMem[lkIdx][lkWay];
        end
    end

    // ---- stage p1: registered prediction ----
    logic             vld_p1, hit_p1;
    logic [31:0]      nextPc_p1;
    logic [2:0]       type_p1;
    logic [WAY_W-1:0] way_p1;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            vld_p1    <= 1'b0;
            hit_p1    <= 1'b0;
            nextPc_p1 <= '0;
            type_p1   <= '0;
            way_p1    <= '0;
        end else begin
            vld_p1    <= InstPcAble;
            hit_p1    <= InstPcAble && lkHit;
            nextPc_p1 <= InstPcAble ? lkNext : '0;
            type_p1   <= InstPcAble ? lkType : '0;
            way_p1    <= InstPcAble ? lkWay  : '0;
        end
    end

    assign InstNextAble = vld_p1;
    assign InstNextHit  = hit_p1;
    assign InstNextPc   = nextPc_p1;
    assign InstNextType = type_p1;
    assign InstNextWay  = way_p1;

    logic [IDX_W-1:0] upIdx;
    logic [TAG_W-1:0] upTag;
    logic             upHit, upIsBr, upAlloc, upWr;
    logic [WAY_W-1:0] upHitWay, victim, nextPtr, wrWay;
    logic [CNT_W-1:0] wrCnt;

    assign upIdx = UpPc[OFF_W+IDX_W-1:OFF_W];
    assign upTag = UpPc[31:OFF_W+IDX_W];

    btb_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) uVictim (
        .validVec(validQ[upIdx]),
        .rrPtr   (rrQ[upIdx]),
        .victim  (victim),
        .nextPtr (nextPtr)
    );

    always_comb begin
        upHit    = 1'b0;
        upHitWay = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (validQ[upIdx][w] && tagMem[upIdx][w] == upTag) begin
                upHit    = 1'b1;
                upHitWay = WAY_W'(w);
            end
        end
        upIsBr  = (UpType == TYPE_BRANCH);
        // A not-taken branch that misses would only predict fall-through, so it is not kept.
        upAlloc = !upHit && !(upIsBr && !UpTaken);
        upWr    = UpAble && !FlushAble && (upHit || upAlloc);
        wrWay   = upHit ? upHitWay : victim;
        if (upHit)
            wrCnt = upIsBr ? CNT_W'(cntSat(4'(cntMem[upIdx][upHitWay]), UpTaken, CNT_W)) : '1;
        else
            wrCnt = CNT_W'(cntInit(UpTaken || !upIsBr, CNT_W));
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest || FlushAble) begin
            for (int s = 0; s < SETS; s++) begin
                validQ[s] <= '0;
                rrQ[s]    <= '0;
            end
        end else if (upWr) begin
            validQ[upIdx][wrWay] <= 1'b1;
            if (!upHit)
                rrQ[upIdx] <= nextPtr;
        end
    end

    always_ff @(posedge Clk) begin
        if (upWr) begin
            tagMem[upIdx][wrWay]  <= upTag;
            typeMem[upIdx][wrWay] <= UpType;
            tgtMem[upIdx][wrWay]  <= UpTaget;
            cntMem[upIdx][wrWay]  <= wrCnt;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed-vector bench for btb_assoc (WAYS=2, SETS=256, CNT_W=2).
module tb_btb_assoc;
    import btb_pkg::*;

    logic        Clk = 1'b0;
    logic        Rest = 1'b0;
    logic        InstPcAble = 1'b0;
    logic [31:0] InstPc = '0;
    logic        UpAble = 1'b0;
    logic [31:0] UpPc = '0;
    logic [2:0]  UpType = '0;
    logic [31:0] UpTaget = '0;
    logic        UpTaken = 1'b0;
    logic        FlushAble = 1'b0;
    logic        InstNextAble;
    logic [31:0] InstNextPc;
    logic [2:0]  InstNextType;
    logic        InstNextHit;
    logic [0:0]  InstNextWay;

    btb_assoc #(.WAYS(2), .SETS(256), .CNT_W(2), .OFF_W(5)) dut (
        .Clk(Clk), .Rest(Rest),
        .InstPcAble(InstPcAble), .InstPc(InstPc),
        .UpAble(UpAble), .UpPc(UpPc), .UpType(UpType), .UpTaget(UpTaget),
        .UpTaken(UpTaken), .FlushAble(FlushAble),
        .InstNextAble(InstNextAble), .InstNextPc(InstNextPc),
        .InstNextType(InstNextType), .InstNextHit(InstNextHit),
        .InstNextWay(InstNextWay)
    );

    always #5 Clk = ~Clk;

    int nVec = 0;
    int nErr = 0;

    // {able, hit, type, pc}
    logic [36:0] obs;
    assign obs = {InstNextAble, InstNextHit, InstNextType, InstNextPc};

    function automatic logic [36:0] ex(input logic a, input logic h, input logic [2:0] t,
                                       input logic [31:0] pc);
        return {a, h, t, pc};
    endfunction

    localparam logic [31:0] PA = 32'h0000_2040, PB = 32'h0000_4040;
    localparam logic [31:0] PC = 32'h0000_6040, PD = 32'h0000_8040;

    task automatic step(input logic lk, input logic [31:0] lkPc, input logic up,
                        input logic [31:0] upPc, input logic [2:0] ty, input logic [31:0] tg,
                        input logic tk, input logic fl);
        @(negedge Clk);
        InstPcAble = lk; InstPc = lkPc;
        UpAble = up; UpPc = upPc; UpType = ty; UpTaget = tg; UpTaken = tk;
        FlushAble = fl;
        @(posedge Clk);
        #1;
        InstPcAble = 1'b0; UpAble = 1'b0; FlushAble = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic [2:0] ty, input logic [31:0] tg,
                          input logic tk);
        step(1'b0, '0, 1'b1, pc, ty, tg, tk, 1'b0);
    endtask

    task automatic test_reset();
        Rest = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        nVec++;
        if ({obs, InstNextWay} !== 38'd0) begin
            nErr++; $display("FAIL reset_outputs: got %h want %h", {obs, InstNextWay}, 38'd0);
        end
        @(negedge Clk);
        Rest = 1'b1;
    endtask

    task automatic test_miss();
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_1020)) begin
            nErr++; $display("FAIL cold_miss: got %h want %h", obs, ex(1, 0, 0, 32'h0000_1020));
        end
        step(1'b0, 32'h0000_1000, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        nVec++;
        if ({obs, InstNextWay} !== 38'd0) begin
            nErr++; $display("FAIL idle_zero: got %h want %h", {obs, InstNextWay}, 38'd0);
        end
        update(32'h0000_A000, TYPE_BRANCH, 32'h0000_BEE0, 1'b0);
        lookup(32'h0000_A000);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_A020)) begin
            nErr++; $display("FAIL nt_no_alloc: got %h want %h", obs, ex(1, 0, 0, 32'h0000_A020));
        end
    endtask

    task automatic test_branch();
        update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b1);
        lookup(32'h0000_1000);
        nVec++;
        if ({obs, InstNextWay} !== {ex(1, 1, TYPE_BRANCH, 32'h0000_4000), 1'b0}) begin
            nErr++; $display("FAIL br_taken_hit: got %h want %h", obs, ex(1, 1, 1, 32'h0000_4000));
        end
        update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b0);
        update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b0);
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 1, TYPE_BRANCH, 32'h0000_1020)) begin
            nErr++; $display("FAIL br_not_taken: got %h want %h", obs, ex(1, 1, 1, 32'h0000_1020));
        end
        // 00 -> 01 -> 10 -> 11 -> 11, then one decrement leaves 10 (taken)
        repeat (4) update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b1);
        update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b0);
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 1, TYPE_BRANCH, 32'h0000_4000)) begin
            nErr++; $display("FAIL cnt_saturate_hi: got %h want %h", obs, ex(1, 1, 1, 32'h0000_4000));
        end
        // Drive to 00, rewrite as JUMP (cnt all ones), then a not-taken BRANCH leaves 10
        update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b0);
        update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b0);
        update(32'h0000_1000, TYPE_JUMP, 32'h0000_4400, 1'b0);
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 1, TYPE_JUMP, 32'h0000_4400)) begin
            nErr++; $display("FAIL jump_hit: got %h want %h", obs, ex(1, 1, 2, 32'h0000_4400));
        end
        update(32'h0000_1000, TYPE_BRANCH, 32'h0000_4000, 1'b0);
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 1, TYPE_BRANCH, 32'h0000_4000)) begin
            nErr++; $display("FAIL nonbr_cnt_ones: got %h want %h", obs, ex(1, 1, 1, 32'h0000_4000));
        end
    endtask

    task automatic test_replace();
        update(PA, TYPE_JUMP, 32'h0000_A0A0, 1'b1);
        update(PB, TYPE_JUMP, 32'h0000_B0B0, 1'b1);
        lookup(PB);
        nVec++;
        if ({obs, InstNextWay} !== {ex(1, 1, TYPE_JUMP, 32'h0000_B0B0), 1'b1}) begin
            nErr++; $display("FAIL fill_b_way1: got %h want %h", {obs, InstNextWay},
                             {ex(1, 1, 2, 32'h0000_B0B0), 1'b1});
        end
        update(PC, TYPE_JUMP, 32'h0000_C0C0, 1'b1);
        lookup(PA);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_2060)) begin
            nErr++; $display("FAIL a_evicted: got %h want %h", obs, ex(1, 0, 0, 32'h0000_2060));
        end
        lookup(PC);
        nVec++;
        if ({obs, InstNextWay} !== {ex(1, 1, TYPE_JUMP, 32'h0000_C0C0), 1'b0}) begin
            nErr++; $display("FAIL c_way0: got %h want %h", {obs, InstNextWay},
                             {ex(1, 1, 2, 32'h0000_C0C0), 1'b0});
        end
        update(PD, TYPE_JUMP, 32'h0000_D0D0, 1'b1);
        lookup(PB);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_4060)) begin
            nErr++; $display("FAIL b_evicted: got %h want %h", obs, ex(1, 0, 0, 32'h0000_4060));
        end
        lookup(PD);
        nVec++;
        if ({obs, InstNextWay} !== {ex(1, 1, TYPE_JUMP, 32'h0000_D0D0), 1'b1}) begin
            nErr++; $display("FAIL d_way1: got %h want %h", {obs, InstNextWay},
                             {ex(1, 1, 2, 32'h0000_D0D0), 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, PC, 1'b1, PC, TYPE_CALL, 32'h0000_C1C0, 1'b1, 1'b0);
        nVec++;
        if (obs !== ex(1, 1, TYPE_JUMP, 32'h0000_C0C0)) begin
            nErr++; $display("FAIL rbw_old: got %h want %h", obs, ex(1, 1, 2, 32'h0000_C0C0));
        end
        lookup(PC);
        nVec++;
        if (obs !== ex(1, 1, TYPE_CALL, 32'h0000_C1C0)) begin
            nErr++; $display("FAIL rbw_new: got %h want %h", obs, ex(1, 1, 3, 32'h0000_C1C0));
        end
    endtask

    task automatic test_wrap();
        lookup(32'hFFFF_FFE0);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_0000)) begin
            nErr++; $display("FAIL wrap_fall: got %h want %h", obs, ex(1, 0, 0, 32'h0));
        end
    endtask

    task automatic test_flush();
        step(1'b1, PD, 1'b1, 32'h0000_E000, TYPE_RET, 32'h0000_E0E0, 1'b1, 1'b1);
        nVec++;
        if (obs !== ex(1, 1, TYPE_JUMP, 32'h0000_D0D0)) begin
            nErr++; $display("FAIL flush_lookup_pre: got %h want %h", obs, ex(1, 1, 2, 32'h0000_D0D0));
        end
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_1020)) begin
            nErr++; $display("FAIL flush_invalidate: got %h want %h", obs, ex(1, 0, 0, 32'h0000_1020));
        end
        lookup(32'h0000_E000);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_E020)) begin
            nErr++; $display("FAIL flush_drops_update: got %h want %h", obs, ex(1, 0, 0, 32'h0000_E020));
        end
    endtask

    task automatic test_midreset();
        update(32'h0000_1000, TYPE_JUMP, 32'h0000_7000, 1'b1);
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 1, TYPE_JUMP, 32'h0000_7000)) begin
            nErr++; $display("FAIL pre_reset_hit: got %h want %h", obs, ex(1, 1, 2, 32'h0000_7000));
        end
        #2;
        Rest = 1'b0;
        #1;
        nVec++;
        if ({obs, InstNextWay} !== 38'd0) begin
            nErr++; $display("FAIL async_reset: got %h want %h", {obs, InstNextWay}, 38'd0);
        end
        @(negedge Clk);
        Rest = 1'b1;
        lookup(32'h0000_1000);
        nVec++;
        if (obs !== ex(1, 0, TYPE_FORMAL, 32'h0000_1020)) begin
            nErr++; $display("FAIL reset_invalidate: got %h want %h", obs, ex(1, 0, 0, 32'h0000_1020));
        end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_branch();
        test_replace();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer; successor of the fixed 2-bank BPU BTB.
- Indexed by fetch-block PC (32-byte blocks). Returns the predicted next fetch PC and branch type one cycle after a lookup; feeds TAGE and RAS.
- Adds over the previous generation: configurable ways, sets and counter width; a real update/allocation path with round-robin replacement; and a flush.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 256, number of sets; power of two, 16..1024.
- CNT_W, 2, saturating direction-counter width; 2..4.
- OFF_W, 5, block offset bits (32-byte fetch block).
- Derived: IDX_W = log2(SETS); TAG_W = 32 - OFF_W - IDX_W; WAY_W = max(1, log2(WAYS)).

Ports:
- Clk  in  1  clock, rising edge.
- Rest  in  1  asynchronous active-low reset.
- InstPcAble  in  1  lookup request.
- InstPc  in  32  lookup fetch PC.
- UpAble  in  1  update request from predecode/commit.
- UpPc  in  32  PC of the resolved control-flow block.
- UpType  in  3  resolved branch type.
- UpTaget  in  32  resolved target.
- UpTaken  in  1  resolved direction; used for BRANCH only.
- FlushAble  in  1  invalidate all entries.
- InstNextAble  out  1  prediction valid.
- InstNextPc  out  32  predicted next fetch PC.
- InstNextType  out  3  predicted type; FORMAL on miss.
- InstNextHit  out  1  lookup hit.
- InstNextWay  out  WAY_W  hit way; 0 on miss.

Behaviour:
- Clock and reset: one clock (Clk). Reset Rest is asynchronous and active-low.
- Reset clears all valid bits, all round-robin pointers and every output to 0.
- Array contents other than the valid bits are undefined after reset; they are never read while invalid.
- Entry fields: valid, tag[TAG_W], type[3], target[32], cnt[CNT_W].
- Address split: idx = PC[OFF_W+IDX_W-1:OFF_W]; tag = PC[31:OFF_W+IDX_W].
- Fall-through address: {PC[31:OFF_W], OFF_W'b0} + 32; wraps modulo 2^32.
- Lookup latency is 1 cycle. Outputs are registered.
  - InstPcAble=0: the next cycle drives all outputs to 0.
  - Hit means valid & tag match. If more than one way matches (must not occur), the lowest way wins.
  - Hit with type BRANCH: InstNextPc = target if cnt[CNT_W-1]=1, else fall-through.
  - Hit with any other type: InstNextPc = target.
  - Miss: InstNextPc = fall-through, type FORMAL, InstNextHit=0.
- Update is applied on the Clk edge when UpAble=1.
  - Hit in the UpPc set: overwrite type and target.
  - Counter on hit: BRANCH taken increments cnt, saturating at all ones; BRANCH not taken decrements, saturating at 0; non-BRANCH types write cnt = all ones.
  - Miss, victim choice: lowest-index invalid way; if none is invalid, the way given by the set's round-robin pointer, after which that pointer increments modulo WAYS.
  - Miss, fill: write valid=1, tag, type, target. cnt = weakly taken (MSB=1, rest 0) if UpTaken, else weakly not-taken (MSB=0, rest 1).
  - The pointer changes only on a replacement of a valid way.
  - A not-taken BRANCH update that misses does not allocate.
- Simultaneous lookup and update to the same set and way: the lookup returns the pre-update contents (read-before-write).
- FlushAble: on the edge, clears all valid bits and pointers; any same-cycle update is dropped. The same-cycle lookup still completes using pre-flush state.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge; any in-flight lookup is lost.

Decomposition:
- Package btb_pkg:
  - Type constants: TYPE_FORMAL=3'd0, TYPE_BRANCH=3'd1, TYPE_JUMP=3'd2, TYPE_CALL=3'd3, TYPE_RET=3'd4.
  - The entry struct, fetch-block size, and the counter init/saturate functions.
- Sub-module btb_victim_sel: valid vector plus round-robin pointer in, victim way and next pointer out. Combinational; instantiated once on the update path.

Test Plan:
- Reset, then lookup 0x0000_1000 -> next cycle InstNextAble=1, Hit=0, Pc=0x0000_1020, Type=0.
- Update 0x0000_1000 BRANCH taken, target 0x0000_4000; then lookup -> Hit=1, Pc=0x0000_4000, Type=1. Two not-taken updates, then lookup -> Pc=0x0000_1020.
- WAYS=2: fill 3 JUMP blocks mapping to the same set (tags A, B, C) -> C replaces way 0. Then a fill with tag D replaces way 1.
- Lookup and update of the same entry in the same cycle -> lookup returns the old target; a lookup next cycle returns the new target.
- Lookup 0xFFFF_FFE0 on a miss -> Pc=0x0000_0000.
- After FlushAble pulse, lookup a previously hit PC -> Hit=0. Assert Rest between edges -> InstNextAble=0 immediately.
